// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: byte/half/word requests onto a word-wide sync-read RAM
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

  state_t                state_q;
  logic                  we_q;
  logic                  uns_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ram_din_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;

  logic                  req_err;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged;

  // Misaligned halves/words and the reserved size code are rejected before any RAM access
  always_comb begin
    req_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Pick the addressed lane out of the read word and extend it for the core
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    load_ext  = ram_dout;
    case (addr_q[1:0])
      2'd0:    byte_lane = ram_dout[7:0];
      2'd1:    byte_lane = ram_dout[15:8];
      2'd2:    byte_lane = ram_dout[23:16];
      default: byte_lane = ram_dout[31:24];
    endcase
    half_lane = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = uns_q ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: load_ext = ram_dout;
    endcase
  end

  // Overlay the store data onto the addressed lane(s) of the word just read
  always_comb begin
    merged = ram_dout;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Request sequencer; response fields only change on the edge that enters RESP
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      wdata_q     <= '0;
      ram_din_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            if (req_err) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= RESP;
            end else if (req_we && (req_size == 2'b10)) begin
              ram_din_q <= req_wdata;
              state_q   <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD:   state_q <= DATA;
        DATA: begin
          if (we_q) begin
            ram_din_q <= merged;
            state_q   <= WR;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_ext;
            state_q     <= RESP;
          end
        end
        WR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state_q     <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign ram_we    = (state_q == WR);
  assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
  assign ram_din   = ram_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  lsu_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous-read, write-first-free RAM model
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at posedge+1 and observe 8 following cycles
  task automatic xact(input string name, input logic we, input logic [13:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_wecyc, input logic [31:0] exp_din);
    int rsp_cyc, rsp_cnt, we_cnt, we_cyc;
    logic [31:0] din_seen, rd_seen;
    logic err_seen;
    rsp_cyc = -1; rsp_cnt = 0; we_cnt = 0; we_cyc = -1;
    din_seen = '0; rd_seen = '0; err_seen = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    check_eq({name, " ready"}, {31'd0, req_ready}, 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        req_valid = 1'b0;
        req_wdata = 32'hA5A5A5A5;
      end
      if (ram_we) begin
        we_cnt++; we_cyc = c; din_seen = ram_din;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; rd_seen = rsp_rdata; err_seen = rsp_err;
        end
      end
    end
    check_eq({name, " rsp_cycle"}, rsp_cyc, exp_lat);
    check_eq({name, " rsp_count"}, rsp_cnt, 1);
    check_eq({name, " rdata"}, rd_seen, exp_rd);
    check_eq({name, " err"}, {31'd0, err_seen}, {31'd0, exp_err});
    check_eq({name, " rdata_hold"}, rsp_rdata, exp_rd);
    check_eq({name, " we_count"}, we_cnt, (exp_wecyc < 0) ? 0 : 1);
    if (exp_wecyc >= 0) begin
      check_eq({name, " we_cycle"}, we_cyc, exp_wecyc);
      check_eq({name, " din"}, din_seen, exp_din);
    end
  endtask

  initial begin
    int acc, rsps;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("rst ram_addr", {20'd0, ram_addr}, 32'd0);
    check_eq("rst ram_din", ram_din, 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    mem[4] = 32'h8899AABB;
    xact("lw",  1'b0, 14'h010, 2'b10, 1'b0, 32'h0, 3, 32'h8899AABB, 1'b0, -1, 32'h0);
    xact("lb",  1'b0, 14'h012, 2'b00, 1'b0, 32'h0, 3, 32'hFFFFFF99, 1'b0, -1, 32'h0);
    xact("lbu", 1'b0, 14'h012, 2'b00, 1'b1, 32'h0, 3, 32'h00000099, 1'b0, -1, 32'h0);
    xact("lh",  1'b0, 14'h012, 2'b01, 1'b0, 32'h0, 3, 32'hFFFF8899, 1'b0, -1, 32'h0);
    xact("lhu", 1'b0, 14'h010, 2'b01, 1'b1, 32'h0, 3, 32'h0000AABB, 1'b0, -1, 32'h0);
    xact("sb",  1'b1, 14'h011, 2'b00, 1'b0, 32'h12345677, 4, 32'h0, 1'b0, 3, 32'h889977BB);
    xact("lw2", 1'b0, 14'h010, 2'b10, 1'b0, 32'h0, 3, 32'h889977BB, 1'b0, -1, 32'h0);
    xact("sh",  1'b1, 14'h012, 2'b01, 1'b0, 32'h0000CAFE, 4, 32'h0, 1'b0, 3, 32'hCAFE77BB);
    check_eq("mem after sh", mem[4], 32'hCAFE77BB);
    xact("sw",  1'b1, 14'h010, 2'b10, 1'b0, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'hDEADBEEF);
    check_eq("mem after sw", mem[4], 32'hDEADBEEF);
    xact("lw3", 1'b0, 14'h010, 2'b10, 1'b0, 32'h0, 3, 32'hDEADBEEF, 1'b0, -1, 32'h0);

    xact("err lh013", 1'b0, 14'h013, 2'b01, 1'b0, 32'h0, 1, 32'h0, 1'b1, -1, 32'h0);
    xact("err lw012", 1'b0, 14'h012, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b1, -1, 32'h0);
    xact("err sz11",  1'b1, 14'h010, 2'b11, 1'b0, 32'h11111111, 1, 32'h0, 1'b1, -1, 32'h0);
    check_eq("mem after errors", mem[4], 32'hDEADBEEF);

    // Abort a sub-word store in its DATA cycle
    mem[4] = 32'h8899AABB;
    xact("lw4", 1'b0, 14'h010, 2'b10, 1'b0, 32'h0, 3, 32'h8899AABB, 1'b0, -1, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h011; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h12345677;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    check_eq("abort ram_we", {31'd0, ram_we}, 32'd0);
    check_eq("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("abort rsp_rdata", rsp_rdata, 32'd0);
    check_eq("abort rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("abort ram_addr", {20'd0, ram_addr}, 32'd0);
    check_eq("abort ram_din", ram_din, 32'd0);
    check_eq("abort req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    acc = 0; rsps = 0;
    for (int c = 0; c < 6; c++) begin
      if (ram_we) acc++;
      if (rsp_valid) rsps++;
      @(posedge clk); #1;
    end
    check_eq("abort late we", acc, 0);
    check_eq("abort late rsp", rsps, 0);
    check_eq("abort req_ready after", {31'd0, req_ready}, 32'd1);
    check_eq("abort mem", mem[4], 32'h8899AABB);

    // Back-to-back loads with req_valid held high
    acc = 0; rsps = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h010; req_size = 2'b10; req_unsigned = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) begin
        rsps++;
        check_eq("held rdata", rsp_rdata, 32'h8899AABB);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check_eq("held accepts", acc, 4);
    check_eq("held responses", rsps, 4);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
